// File: rtl/billiard_video_pkg.sv
// Shared billiard video definitions: default colour format and layer order.
// The layer constants are positional priorities (0 = drawn on top).
package billiard_video_pkg;

  localparam int DEF_RGB_W  = 8;
  localparam int DEF_BG_RGB = 0;

  localparam int LAYER_HOLE0      = 0;
  localparam int LAYER_HOLE1      = 1;
  localparam int LAYER_HOLE2      = 2;
  localparam int LAYER_HOLE3      = 3;
  localparam int LAYER_HOLE4      = 4;
  localparam int LAYER_HOLE5      = 5;
  localparam int LAYER_WHITE_BALL = 6;
  localparam int LAYER_RED_BALL   = 7;
  localparam int LAYER_BORDER     = 8;
  localparam int LAYER_BOARD      = 9;

  localparam int NUM_GAME_LAYERS  = 10;

endpackage

// File: rtl/layered_objects_mux_prio_encoder.sv
// Lowest-index priority encoder. Ports: req_i request vector;
// idx_o lowest set bit (0 if none), any_o any bit set, multi_o two or more set.
module prio_encoder #(
  parameter  int W  = 10,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o,
  output logic          multi_o
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IW'(i);
      end
    end
  end

  assign any_o = |req_i;

  // Clearing the lowest set bit leaves something only if >= 2 bits were set.
  assign multi_o = |(req_i & (req_i - W'(1)));

endmodule

// File: rtl/layered_objects_mux.sv
// N-layer drawing-priority mux, 2-stage pipeline, plus per-frame overlap map.
// Ports: clk/reset, pixel_valid/start_of_frame, draw_req/rgb_in/layer_en in;
// rgb_out/out_valid/out_hit/out_layer and frame_overlap/overlap_update out.
module layered_objects_mux
  import billiard_video_pkg::*;
#(
  parameter  int                 NUM_LAYERS = NUM_GAME_LAYERS,
  parameter  int                 RGB_W      = DEF_RGB_W,
  parameter  logic [RGB_W-1:0]   BG_RGB     = RGB_W'(DEF_BG_RGB),
  localparam int                 IDX_W      = $clog2(NUM_LAYERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pixel_valid,
  input  logic                        start_of_frame,
  input  logic [NUM_LAYERS-1:0]       draw_req,
  input  logic [NUM_LAYERS*RGB_W-1:0] rgb_in,
  input  logic [NUM_LAYERS-1:0]       layer_en,
  output logic [RGB_W-1:0]            rgb_out,
  output logic                        out_valid,
  output logic                        out_hit,
  output logic [IDX_W-1:0]            out_layer,
  output logic [NUM_LAYERS-1:0]       frame_overlap,
  output logic                        overlap_update
);

  // Stage 1
  logic [NUM_LAYERS-1:0]       mreq_q;
  logic [NUM_LAYERS*RGB_W-1:0] rgb_q;
  logic                        pv_q;
  logic                        sof_q;

  // Stage 2
  logic [RGB_W-1:0]      rgb_out_q, rgb_out_d;
  logic                  valid_q;
  logic                  hit_q;
  logic [IDX_W-1:0]      layer_q, layer_d;
  logic [NUM_LAYERS-1:0] acc_q, acc_d;
  logic [NUM_LAYERS-1:0] fov_q, fov_d;
  logic                  upd_q, upd_d;

  logic [IDX_W-1:0]      win_idx;
  logic                  win_any;
  logic                  win_multi;
  logic [RGB_W-1:0]      sel_rgb;
  logic [NUM_LAYERS-1:0] pix_ov;

  always_ff @(posedge clk) begin
    if (reset) begin
      mreq_q <= '0;
      rgb_q  <= '0;
      pv_q   <= 1'b0;
      sof_q  <= 1'b0;
    end else begin
      mreq_q <= draw_req & layer_en;
      rgb_q  <= rgb_in;
      pv_q   <= pixel_valid;
      sof_q  <= start_of_frame;
    end
  end

  prio_encoder #(
    .W (NUM_LAYERS)
  ) u_prio (
    .req_i   (mreq_q),
    .idx_o   (win_idx),
    .any_o   (win_any),
    .multi_o (win_multi)
  );

  always_comb begin
    sel_rgb = BG_RGB;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_rgb = rgb_q[i*RGB_W +: RGB_W];
      end
    end
  end

  assign pix_ov = win_multi ? mreq_q : '0;

  always_comb begin
    rgb_out_d = win_any ? sel_rgb : BG_RGB;
    layer_d   = win_any ? win_idx : '0;
    acc_d     = acc_q;
    fov_d     = fov_q;
    upd_d     = 1'b0;
    // Invalid slots leave the overlap state alone, even if SOF is set.
    if (pv_q) begin
      if (sof_q) begin
        fov_d = acc_q;
        upd_d = 1'b1;
        acc_d = pix_ov;
      end else begin
        acc_d = acc_q | pix_ov;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_out_q <= BG_RGB;
      valid_q   <= 1'b0;
      hit_q     <= 1'b0;
      layer_q   <= '0;
      acc_q     <= '0;
      fov_q     <= '0;
      upd_q     <= 1'b0;
    end else begin
      rgb_out_q <= rgb_out_d;
      valid_q   <= pv_q;
      hit_q     <= win_any;
      layer_q   <= layer_d;
      acc_q     <= acc_d;
      fov_q     <= fov_d;
      upd_q     <= upd_d;
    end
  end

  assign rgb_out        = rgb_out_q;
  assign out_valid      = valid_q;
  assign out_hit        = hit_q;
  assign out_layer      = layer_q;
  assign frame_overlap  = fov_q;
  assign overlap_update = upd_q;

endmodule
